// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
// Issue controller for the register-file/ALU/writeback/store pipeline.
// Incoming instruction words are buffered in a small FIFO. At most one is
// issued per clock. Issue stalls on read-after-write hazards against
// in-flight destinations, and illegal func codes are dropped. A drain
// handshake lets software quiesce the pipeline.
// Optional feature: define PIPE_ISSUE_STALLCNT_EN to add the stall_cnt
// output, a saturating count of hazard-stalled clocks.

module pipe_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_rs1,
    input  logic [3:0]       in_rs2,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_func,
    input  logic [7:0]       in_addr,
    input  logic             en,
    input  logic             drain_req,
    output logic             drain_done,
    output logic             iss_valid,
    output logic [3:0]       iss_rs1,
    output logic [3:0]       iss_rs2,
    output logic [3:0]       iss_rd,
    output logic [3:0]       iss_func,
    output logic [7:0]       iss_addr,
    output logic             err_illegal,
    output logic [CNT_W-1:0] issue_cnt
`ifdef PIPE_ISSUE_STALLCNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs2;
        logic [3:0] rs1;
    } instr_t;

    state_t            state_q, state_d;
    instr_t            mem_q [DEPTH];
    logic [AW:0]       wrPtr_q, rdPtr_q;
    logic [WB_LAT-1:0] sbValid_q;
    logic [3:0]        sbRd_q [WB_LAT];
    instr_t            iss_q;
    logic              issValid_q;
    logic              errIllegal_q;
    logic [CNT_W-1:0]  issueCnt_q;

    instr_t head;
    instr_t inWord;
    logic   empty, full, illegal, hazard;
    logic   doIssue, doDrop, push, pop, sbIdle;

    assign inWord   = {in_addr, in_func, in_rd, in_rs2, in_rs1};
    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign head     = mem_q[rdPtr_q[AW-1:0]];
    assign in_ready = !full && (state_q == RUN) && !rst;
    assign push     = in_valid && in_ready;
    assign illegal  = (head.func > 4'd11);
    assign sbIdle   = (sbValid_q == '0);
    assign doDrop   = !empty && illegal;
    assign doIssue  = !empty && !illegal && en && !hazard;
    assign pop      = doDrop || doIssue;

    // The head is blocked if any pending writeback targets either source.
    // Both sources are checked for every func.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sbValid_q[i] && (sbRd_q[i] == head.rs1 || sbRd_q[i] == head.rs2)) begin
                hazard = 1'b1;
            end
        end
    end

    // Drain handshake: leave RUN on request, finish once nothing is buffered
    // or pending, and return to RUN whenever the request drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)           state_d = RUN;
                else if (empty && sbIdle) state_d = DONE;
            end
            DONE: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FIFO storage. Contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= inWord;
        end
    end

    // Pointers, state, issue registers, counter and writeback scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            issValid_q   <= 1'b0;
            errIllegal_q <= 1'b0;
            iss_q        <= '0;
            issueCnt_q   <= '0;
            sbValid_q    <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                sbRd_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            issValid_q   <= doIssue;
            errIllegal_q <= doDrop;
            if (push) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (pop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
            if (doIssue) begin
                iss_q      <= head;
                issueCnt_q <= issueCnt_q + CNT_W'(1);
            end
            sbValid_q[0] <= doIssue;
            sbRd_q[0]    <= head.rd;
            for (int i = 1; i < WB_LAT; i++) begin
                sbValid_q[i] <= sbValid_q[i-1];
                sbRd_q[i]    <= sbRd_q[i-1];
            end
        end
    end

    assign drain_done  = (state_q == DONE);
    assign iss_valid   = issValid_q;
    assign iss_rs1     = iss_q.rs1;
    assign iss_rs2     = iss_q.rs2;
    assign iss_rd      = iss_q.rd;
    assign iss_func    = iss_q.func;
    assign iss_addr    = iss_q.addr;
    assign err_illegal = errIllegal_q;
    assign issue_cnt   = issueCnt_q;

`ifdef PIPE_ISSUE_STALLCNT_EN
    logic [CNT_W-1:0] stallCnt_q;

    // Count clocks where a legal head would issue except for a hazard.
    // The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else if (!empty && en && !illegal && hazard && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule
